// File: rtl/wb_regfile.sv
// Writeback stage: arbitrates add/mul results onto one register-file write port
// (add first, mul queued in a small FIFO) and serves two combinational read ports.
// Optional same-cycle read forwarding is enabled by defining WB_BYPASS_EN.
module wb_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   add_valid,
  input  logic [WIDTH-1:0]       add_data,
  input  logic [4:0]             add_rd,
  input  logic                   mul_valid,
  input  logic [WIDTH-1:0]       mul_data,
  input  logic [4:0]             mul_rd,
  output logic                   mul_ready,
  input  logic [4:0]             ra1,
  input  logic [4:0]             ra2,
  output logic [WIDTH-1:0]       rd1,
  output logic [WIDTH-1:0]       rd2,
  output logic                   wb_valid,
  output logic [4:0]             wb_rd,
  output logic [WIDTH-1:0]       wb_data,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] regs_q      [32];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [4:0]       fifo_rd_q   [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wb_valid_q;
  logic [4:0]       wb_rd_q;
  logic [WIDTH-1:0] wb_data_q;

  logic             push, pop, we;
  logic [4:0]       wr_rd;
  logic [WIDTH-1:0] wr_data;

  // Ready depends on occupancy only, so a full FIFO rejects even when popping.
  assign mul_ready = (count_q != CW'(DEPTH));
  assign push      = mul_valid && mul_ready;
  assign pop       = !add_valid && (count_q != '0);
  assign we        = add_valid || pop;
  assign wr_rd     = add_valid ? add_rd   : fifo_rd_q[rptr_q];
  assign wr_data   = add_valid ? add_data : fifo_data_q[rptr_q];

  always_comb begin
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    overflow_d = overflow_q || (mul_valid && !mul_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wb_valid_q <= we;
      if (we) begin
        wb_rd_q   <= wr_rd;
        wb_data_q <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wptr_q] <= mul_data;
      fifo_rd_q[wptr_q]   <= mul_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (wr_rd != 5'd0)) begin
      regs_q[wr_rd] <= wr_data;
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
    if (we && (wr_rd == ra1)) rd1 = wr_data;
    if (we && (wr_rd == ra2)) rd2 = wr_data;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end
`else
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
  end
`endif

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign pending  = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for the single-cycle behaviour plus
// hand sequences for mid-queue reset, full-FIFO pop/reject and push+pop together.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        add_valid, mul_valid;
  logic [31:0] add_data, mul_data;
  logic [4:0]  add_rd, mul_rd, ra1, ra2;
  logic        mul_ready, wb_valid, overflow;
  logic [31:0] rd1, rd2, wb_data;
  logic [4:0]  wb_rd;
  logic [2:0]  pending;

  int total = 0;
  int bad   = 0;

  wb_regfile #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .add_valid(add_valid), .add_data(add_data), .add_rd(add_rd),
    .mul_valid(mul_valid), .mul_data(mul_data), .mul_rd(mul_rd),
    .mul_ready(mul_ready), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic [4:0]  ra1; logic [4:0] ra2;
    logic [31:0] e_rd1; logic [31:0] e_rd2;
    logic        e_wbv; logic [4:0] e_wbrd; logic [31:0] e_wbd;
    logic [2:0]  e_pend; logic e_rdy; logic e_ovf;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    add_valid = av; add_rd = ard; add_data = ad;
    mul_valid = mv; mul_rd = mrd; mul_data = md;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_wb(input string name, input logic [4:0] r, input logic [31:0] d,
                        input logic [2:0] p);
    chk({name, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({name, ".wb_rd"},    32'(wb_rd),    32'(r));
    chk({name, ".wb_data"},  wb_data,       d);
    chk({name, ".pending"},  32'(pending),  32'(p));
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".pending"},   32'(pending),   32'd0);
    chk({name, ".wb_valid"},  32'(wb_valid),  32'd0);
    chk({name, ".wb_rd"},     32'(wb_rd),     32'd0);
    chk({name, ".wb_data"},   wb_data,        32'd0);
    chk({name, ".mul_ready"}, 32'(mul_ready), 32'd1);
    chk({name, ".overflow"},  32'(overflow),  32'd0);
    for (int r = 0; r < 32; r++) begin
      ra1 = 5'(r); ra2 = 5'(31 - r);
      #0;
      chk($sformatf("%s.rd1[%0d]", name, r), rd1, 32'd0);
      chk($sformatf("%s.rd2[%0d]", name, 31 - r), rd2, 32'd0);
    end
  endtask

  function automatic vec_t v(logic av, logic [4:0] ard, logic [31:0] ad,
                             logic mv, logic [4:0] mrd, logic [31:0] md,
                             logic [4:0] a1, logic [4:0] a2,
                             logic [31:0] e1, logic [31:0] e2,
                             logic ewv, logic [4:0] ewr, logic [31:0] ewd,
                             logic [2:0] ep, logic er, logic eo);
    vec_t t;
    t.av = av; t.ard = ard; t.ad = ad; t.mv = mv; t.mrd = mrd; t.md = md;
    t.ra1 = a1; t.ra2 = a2; t.e_rd1 = e1; t.e_rd2 = e2;
    t.e_wbv = ewv; t.e_wbrd = ewr; t.e_wbd = ewd;
    t.e_pend = ep; t.e_rdy = er; t.e_ovf = eo;
    return t;
  endfunction

  initial begin
    //          av ard ad             mv mrd md        ra1 ra2 rd1           rd2  wbv wbrd wbd           pend rdy ovf
    vt[0]  = v(0, 0,  0,             0, 0,  0,        5,  0,  0,            0,   0, 0,  0,            0,   1,  0);
    vt[1]  = v(1, 5,  32'h12345678,  0, 0,  0,        5,  0,  32'h12345678, 0,   1, 5,  32'h12345678, 0,   1,  0);
    vt[2]  = v(0, 0,  0,             0, 0,  0,        5,  5,  32'h12345678, 32'h12345678, 0, 0, 0,    0,   1,  0);
    vt[3]  = v(1, 3,  7,             1, 4,  9,        3,  4,  7,            0,   1, 3,  7,            1,   1,  0);
    vt[4]  = v(0, 0,  0,             0, 0,  0,        3,  4,  7,            9,   1, 4,  9,            0,   1,  0);
    vt[5]  = v(1, 0,  32'hFFFFFFFF,  0, 0,  0,        0,  5,  0,            32'h12345678, 1, 0, 32'hFFFFFFFF, 0, 1, 0);
    vt[6]  = v(0, 0,  0,             1, 0,  32'hAAAA, 0,  4,  0,            9,   0, 0,  0,            1,   1,  0);
    vt[7]  = v(0, 0,  0,             0, 0,  0,        0,  3,  0,            7,   1, 0,  32'hAAAA,     0,   1,  0);
    vt[8]  = v(1, 1,  32'h11,        1, 10, 32'hA0,   1,  10, 32'h11,       0,   1, 1,  32'h11,       1,   1,  0);
    vt[9]  = v(1, 1,  32'h12,        1, 11, 32'hA1,   1,  11, 32'h12,       0,   1, 1,  32'h12,       2,   1,  0);
    vt[10] = v(1, 1,  32'h13,        1, 12, 32'hA2,   1,  12, 32'h13,       0,   1, 1,  32'h13,       3,   1,  0);
    vt[11] = v(1, 1,  32'h14,        1, 13, 32'hA3,   1,  13, 32'h14,       0,   1, 1,  32'h14,       4,   0,  0);
    vt[12] = v(1, 1,  32'h15,        1, 14, 32'hA4,   1,  14, 32'h15,       0,   1, 1,  32'h15,       4,   0,  1);
    vt[13] = v(0, 0,  0,             0, 0,  0,        10, 11, 32'hA0,       0,   1, 10, 32'hA0,       3,   1,  1);
    vt[14] = v(0, 0,  0,             0, 0,  0,        11, 12, 32'hA1,       0,   1, 11, 32'hA1,       2,   1,  1);
    vt[15] = v(0, 0,  0,             0, 0,  0,        12, 13, 32'hA2,       0,   1, 12, 32'hA2,       1,   1,  1);
    vt[16] = v(0, 0,  0,             0, 0,  0,        13, 14, 32'hA3,       0,   1, 13, 32'hA3,       0,   1,  1);
    vt[17] = v(0, 0,  0,             0, 0,  0,        13, 1,  32'hA3,       32'h15, 0, 0, 0,          0,   1,  1);

    drive(0, 0, 0, 0, 0, 0);
    ra1 = 0; ra2 = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].mv, vt[i].mrd, vt[i].md);
      ra1 = vt[i].ra1; ra2 = vt[i].ra2;
      step();
      chk($sformatf("v%0d.rd1", i),      rd1,                vt[i].e_rd1);
      chk($sformatf("v%0d.rd2", i),      rd2,                vt[i].e_rd2);
      chk($sformatf("v%0d.wb_valid", i), 32'(wb_valid),      32'(vt[i].e_wbv));
      if (vt[i].e_wbv) begin
        chk($sformatf("v%0d.wb_rd", i),   32'(wb_rd),        32'(vt[i].e_wbrd));
        chk($sformatf("v%0d.wb_data", i), wb_data,           vt[i].e_wbd);
      end
      chk($sformatf("v%0d.pending", i),  32'(pending),       32'(vt[i].e_pend));
      chk($sformatf("v%0d.mul_ready", i),32'(mul_ready),     32'(vt[i].e_rdy));
      chk($sformatf("v%0d.overflow", i), 32'(overflow),      32'(vt[i].e_ovf));
    end

    // Reset asserted between edges while the FIFO holds entries.
    drive(1, 2, 32'h55, 1, 7, 32'h77); step();
    drive(1, 2, 32'h56, 1, 8, 32'h88); step();
    chk("midq.pending_before", 32'(pending), 32'd2);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_reset("midq");
    step();
    rst = 1'b0;
    step();
    chk("midq.idle_wb_valid", 32'(wb_valid), 32'd0);
    chk("midq.flushed", 32'(pending), 32'd0);
    ra1 = 7; ra2 = 8; #0;
    chk("midq.r7", rd1, 32'd0);
    chk("midq.r8", rd2, 32'd0);

    // Full FIFO with add idle: pop happens, push rejected.
    for (int k = 0; k < 4; k++) begin
      drive(1, 2, 32'(k), 1, 5'(20 + k), 32'hB0 + 32'(k));
      step();
    end
    chk("full.ready", 32'(mul_ready), 32'd0);
    chk("full.ovf0", 32'(overflow), 32'd0);
    drive(0, 0, 0, 1, 30, 32'hDEAD); step();
    chk_wb("full_pop", 20, 32'hB0, 3);
    chk("full.ovf1", 32'(overflow), 32'd1);
    chk("full.ready_after", 32'(mul_ready), 32'd1);
    // Simultaneous push and pop keeps occupancy.
    drive(0, 0, 0, 1, 31, 32'hBEEF); step();
    chk_wb("pushpop", 21, 32'hB1, 3);
    drive(0, 0, 0, 0, 0, 0); step();
    chk_wb("drain0", 22, 32'hB2, 2);
    step();
    chk_wb("drain1", 23, 32'hB3, 1);
    step();
    chk_wb("drain2", 31, 32'hBEEF, 0);
    step();
    chk("drain.idle", 32'(wb_valid), 32'd0);
    ra1 = 30; ra2 = 31; #0;
    chk("dropped.r30", rd1, 32'd0);
    chk("kept.r31", rd2, 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
